// File: rtl/seven_seg_rx_pkg.sv
// Shared seven-segment definitions for the display driver and the bus receiver.
// Segment lines are active low, ordered {a,b,c,d,e,f,g,dp}.
package seven_seg_rx_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // segs[7:1] with every segment dark
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Full 8-bit codes for hex digits 0..F, decimal point off
    localparam logic [7:0] SEG_CODE [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/seven_seg_rx_decode.sv
// Combinational segment-pattern decoder: segs[7:1] -> {nibble, blank, illegal}.
module seg_pattern_decode
    import seven_seg_rx_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       illegal_o
);

    logic match;

    // Search the code table; dark and unknown patterns both yield nibble 0
    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = 1'b0;
        illegal_o = 1'b0;
        match     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_CODE[i][7:1]) begin
                nibble_o = 4'(i);
                match    = 1'b1;
            end
        end
        if (seg_i == SEG_BLANK) begin
            blank_o = 1'b1;
        end else if (!match) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_rx.sv
// Multiplexed 4-digit seven-segment bus receiver: waits for each strobe to
// settle, decodes it into a slot, and publishes a frame once all 4 slots are seen.
module seven_seg_rx
    import seven_seg_rx_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_display,
    input  logic [7:0]  segs,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        anode_err,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [20:0] TIMEOUT_MAX = 21'(TIMEOUT_CYC);

    logic [11:0] sync1_q, pair_q, prev_q;
    logic [3:0]  anodes;
    logic [7:0]  pat;
    logic        changed, all_high, one_low;

    rx_state_e   state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic        sample, anode_err_d;

    logic [3:0]  dec_nib;
    logic        dec_blank, dec_ill;
    logic [3:0]  slot_hit;

    logic [3:0][3:0] slot_nib_q;
    logic [3:0]  slot_dp_q, slot_blank_q;
    logic [3:0]  seen_q, seen_d, ill_q, ill_d;
    logic        frame_done;

    logic [15:0] value_q;
    logic [3:0]  dp_q, blank_q;
    logic        frame_valid_q, frame_err_q, anode_err_q;
    logic [20:0] stale_cnt_q, stale_cnt_d;

    assign anodes     = pair_q[11:8];
    assign pat        = pair_q[7:0];
    assign changed    = (pair_q != prev_q);
    assign all_high   = (anodes == 4'hF);
    assign one_low    = $onehot(~anodes);
    assign frame_done = (seen_q == 4'hF);
    assign slot_hit   = sample ? ~anodes : 4'h0;

    // Double-register the bus and keep one older copy for change detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 12'hFFF;
            pair_q  <= 12'hFFF;
            prev_q  <= 12'hFFF;
        end else begin
            sync1_q <= {digit_display, segs};
            pair_q  <= sync1_q;
            prev_q  <= pair_q;
        end
    end

    // FSM state and settle counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            settle_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next state: a strobe must stay unchanged SETTLE_CYC cycles to be sampled once
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        sample      = 1'b0;
        anode_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                settle_d = 8'd0;
                if (!all_high) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (all_high) begin
                    state_d  = ST_IDLE;
                    settle_d = 8'd0;
                end else if (changed) begin
                    settle_d = 8'd0;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = 8'd0;
                    state_d  = ST_HOLD;
                    if (one_low) sample = 1'b1;
                    else         anode_err_d = 1'b1;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_HOLD: begin
                settle_d = 8'd0;
                if (changed) state_d = all_high ? ST_IDLE : ST_SETTLE;
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = 8'd0;
            end
        endcase
    end

    seg_pattern_decode u_decode (
        .seg_i     (pat[7:1]),
        .nibble_o  (dec_nib),
        .blank_o   (dec_blank),
        .illegal_o (dec_ill)
    );

    // Per-slot storage; a re-sample of a slot simply overwrites it
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_nib_q[gi]   <= 4'h0;
                    slot_dp_q[gi]    <= 1'b0;
                    slot_blank_q[gi] <= 1'b0;
                end else if (slot_hit[gi]) begin
                    slot_nib_q[gi]   <= dec_nib;
                    slot_dp_q[gi]    <= ~pat[SEG_DP_BIT];
                    slot_blank_q[gi] <= dec_blank;
                end
            end
        end
    endgenerate

    // Seen/illegal masks restart in the assembly cycle; a sample then joins the new frame
    always_comb begin
        seen_d = frame_done ? 4'h0 : seen_q;
        ill_d  = frame_done ? 4'h0 : ill_q;
        seen_d = seen_d | slot_hit;
        ill_d  = (ill_d & ~slot_hit) | (slot_hit & {4{dec_ill}});
    end

    // Frame assembly: publish slots one cycle after the mask fills
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_q        <= 4'h0;
            ill_q         <= 4'h0;
            value_q       <= 16'h0;
            dp_q          <= 4'h0;
            blank_q       <= 4'hF;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            seen_q        <= seen_d;
            ill_q         <= ill_d;
            frame_valid_q <= frame_done;
            anode_err_q   <= anode_err_d;
            if (frame_done) begin
                value_q     <= slot_nib_q;
                dp_q        <= slot_dp_q;
                blank_q     <= slot_blank_q;
                frame_err_q <= |ill_q;
            end
        end
    end

    // Saturating stall counter, cleared by every sample
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (sample)                          stale_cnt_d = 21'd0;
        else if (stale_cnt_q != TIMEOUT_MAX) stale_cnt_d = stale_cnt_q + 21'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stale_cnt_q <= 21'd0;
        else        stale_cnt_q <= stale_cnt_d;
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign anode_err   = anode_err_q;
    assign stale       = (stale_cnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx with hand-computed expectations.
module tb_seven_seg_rx;

    localparam logic [7:0] S1 = 8'b10011111, S2 = 8'b00100101, S3 = 8'b00001101;
    localparam logic [7:0] S4 = 8'b10011001, S5 = 8'b01001001, S6 = 8'b01000001;
    localparam logic [7:0] S7 = 8'b00011111, S8 = 8'b00000001, S9 = 8'b00001001;
    localparam logic [7:0] SA = 8'b00010001, SB = 8'b11000001, SC = 8'b01100011;
    localparam logic [7:0] SD = 8'b10000101, SE = 8'b01100001, SF = 8'b01110001;

    logic        clk, reset;
    logic [3:0]  digit_display;
    logic [7:0]  segs;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic        frame_valid, frame_err, anode_err, stale;

    int n_cmp = 0, n_err = 0;
    int fv_cnt = 0, ae_cnt = 0;
    int fv0, ae0;

    seven_seg_rx #(.SETTLE_CYC(16), .TIMEOUT_CYC(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .digit_display (digit_display),
        .segs          (segs),
        .value         (value),
        .dp            (dp),
        .blank         (blank),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .anode_err     (anode_err),
        .stale         (stale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (anode_err)   ae_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int d, input logic [7:0] code, input int cyc);
        logic [3:0] one;
        one = 4'b0001 << d;
        digit_display = ~one;
        segs = code;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        digit_display = 4'hF;
        segs = 8'hFF;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        digit_display = 4'hF;
        segs = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_value", value, 16'h0000);
        check("rst_dp", {12'h0, dp}, 16'h0000);
        check("rst_blank", {12'h0, blank}, 16'h000F);
        check("rst_fv", {15'h0, frame_valid}, 16'h0000);
        check("rst_ferr", {15'h0, frame_err}, 16'h0000);
        check("rst_aerr", {15'h0, anode_err}, 16'h0000);
        check("rst_stale", {15'h0, stale}, 16'h0000);
        reset = 1'b1;

        // Scan 1,2,3,4 on digits 0..3
        fv0 = fv_cnt;
        strobe(0, S1, 40); strobe(1, S2, 40); strobe(2, S3, 40); strobe(3, S4, 40);
        idle(10);
        $display("scan 4321: fv=%0d value=%h", fv_cnt - fv0, value);
        check("t1_fv", 16'(fv_cnt - fv0), 16'd1);
        check("t1_value", value, 16'h4321);
        check("t1_dp", {12'h0, dp}, 16'h0000);
        check("t1_blank", {12'h0, blank}, 16'h0000);
        check("t1_ferr", {15'h0, frame_err}, 16'h0000);

        // Short digit2 strobe: no frame; the later full pass completes it
        pulse_reset();
        fv0 = fv_cnt;
        strobe(0, S5, 40); strobe(1, S6, 40); strobe(2, S7, 10); strobe(3, S8, 40);
        idle(10);
        $display("short pass: fv=%0d", fv_cnt - fv0);
        check("t2_short_fv", 16'(fv_cnt - fv0), 16'd0);
        strobe(0, S9, 40); strobe(1, SA, 40); strobe(2, SB, 40);
        idle(10);
        $display("full pass: fv=%0d value=%h", fv_cnt - fv0, value);
        check("t2_full_fv", 16'(fv_cnt - fv0), 16'd1);
        check("t2_value", value, 16'h8BA9);

        // Dark digit with dp, and an illegal pattern
        pulse_reset();
        fv0 = fv_cnt;
        strobe(0, S1, 40); strobe(1, 8'b11111110, 40);
        strobe(2, S3, 40); strobe(3, 8'b10101011, 40);
        idle(10);
        $display("err frame: fv=%0d value=%h dp=%b blank=%b ferr=%b",
                 fv_cnt - fv0, value, dp, blank, frame_err);
        check("t3_fv", 16'(fv_cnt - fv0), 16'd1);
        check("t3_value", value, 16'h0301);
        check("t3_dp", {12'h0, dp}, 16'h0002);
        check("t3_blank", {12'h0, blank}, 16'h0002);
        check("t3_ferr", {15'h0, frame_err}, 16'h0001);

        // Two anodes low: one anode_err pulse, no sample
        pulse_reset();
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        digit_display = 4'b1100;
        segs = S8;
        repeat (40) @(negedge clk);
        idle(10);
        $display("two anodes: aerr=%0d fv=%0d", ae_cnt - ae0, fv_cnt - fv0);
        check("t4_aerr", 16'(ae_cnt - ae0), 16'd1);
        check("t4_fv_none", 16'(fv_cnt - fv0), 16'd0);
        strobe(0, S5, 40); strobe(1, S6, 40); strobe(2, S7, 40); strobe(3, S8, 40);
        idle(10);
        $display("scan 8765: fv=%0d value=%h", fv_cnt - fv0, value);
        check("t4_fv", 16'(fv_cnt - fv0), 16'd1);
        check("t4_value", value, 16'h8765);

        // Stall: about 31 cycles since last sample here, then past 64
        check("t5_not_stale", {15'h0, stale}, 16'h0000);
        idle(50);
        $display("stall: stale=%b", stale);
        check("t5_stale", {15'h0, stale}, 16'h0001);
        strobe(0, S5, 40);
        $display("resume: stale=%b", stale);
        check("t5_resume", {15'h0, stale}, 16'h0000);

        // Reset after slots 0..2 sampled; the next frame needs all four again
        strobe(1, S2, 40); strobe(2, S3, 40);
        idle(5);
        #2 reset = 1'b0;
        #1;
        $display("mid-frame reset: value=%h blank=%b", value, blank);
        check("t6_value", value, 16'h0000);
        check("t6_blank", {12'h0, blank}, 16'h000F);
        check("t6_dp", {12'h0, dp}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        fv0 = fv_cnt;
        strobe(3, SE, 40); strobe(0, SD, 40); strobe(1, SC, 40);
        idle(10);
        check("t6_partial_fv", 16'(fv_cnt - fv0), 16'd0);
        strobe(2, SF, 40);
        idle(10);
        $display("after reset: fv=%0d value=%h", fv_cnt - fv0, value);
        check("t6_fv", 16'(fv_cnt - fv0), 16'd1);
        check("t6_new_value", value, 16'hEFCD);
        check("t6_ferr", {15'h0, frame_err}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
